// File: rtl/hpdmc_pkg.sv
// Shared definitions for the 32-bit WISHBONE front-end of the memory controller:
// FSM state encoding, WISHBONE cycle-type codes and read-line geometry.
package hpdmc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam int LINE_BEATS = 4;
  localparam int LINE_BYTES = 32;

endpackage

// File: rtl/hpdmc_wb32_linebuf.sv
// One-line read buffer: four 64-bit beats, written whole during a burst fill or
// byte-masked by write-through hits, read asynchronously as 32-bit words.
module hpdmc_wb32_linebuf
  import hpdmc_pkg::*;
(
  input  logic        clk_i,
  input  logic        fill_we_i,
  input  logic [1:0]  fill_beat_i,
  input  logic [63:0] fill_dat_i,
  input  logic        upd_we_i,
  input  logic [2:0]  upd_idx_i,
  input  logic [3:0]  upd_sel_i,
  input  logic [31:0] upd_dat_i,
  input  logic [2:0]  rd_idx_i,
  output logic [31:0] rd_dat_o
);

  logic [63:0] mem_q [LINE_BEATS];
  logic [7:0]  upd_sel8;
  logic [63:0] upd_mask;
  logic [63:0] rd_beat;

  // Word-select 0 is the upper half of a beat (big-endian lane order).
  always_comb begin
    upd_sel8 = upd_idx_i[0] ? {4'b0000, upd_sel_i} : {upd_sel_i, 4'b0000};
    upd_mask = '0;
    for (int i = 0; i < 8; i++) begin
      upd_mask[8*i +: 8] = {8{upd_sel8[i]}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      mem_q[fill_beat_i] <= fill_dat_i;
    end else if (upd_we_i) begin
      mem_q[upd_idx_i[2:1]] <= (mem_q[upd_idx_i[2:1]] & ~upd_mask) |
                               ({upd_dat_i, upd_dat_i} & upd_mask);
    end
  end

  assign rd_beat  = mem_q[rd_idx_i[2:1]];
  assign rd_dat_o = rd_idx_i[0] ? rd_beat[31:0] : rd_beat[63:32];

endmodule

// File: rtl/hpdmc_wb32_bridge.sv
// 32-bit WISHBONE slave to 64-bit memory port bridge with a one-line read buffer.
// Define HPDMC_WB32_NEXTADR_EN to drive the next-line address prediction sideband.
module hpdmc_wb32_bridge
  import hpdmc_pkg::*;
#(
  parameter int sdram_depth = 26
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        invalidate,
  input  logic [31:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  output logic [31:0] s_dat_o,
  input  logic [3:0]  s_sel_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  output logic        s_ack_o,
  output logic [31:0] m_adr_o,
  output logic [2:0]  m_cti_o,
  output logic [63:0] m_dat_o,
  input  logic [63:0] m_dat_i,
  output logic [7:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  input  logic        m_ack_i,
  output logic        m_nextadr_valid_o,
  output logic [31:0] m_nextadr_o
);

  localparam int TAG_W = sdram_depth - 5;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [1:0]       beat_q, beat_d;
  logic [31:2]      adr_q, adr_d;
  logic [31:0]      sdat_q, sdat_d;
  logic             inval_seen_q, inval_seen_d;
  logic             dropped_q, dropped_d;

  logic             fill_we;
  logic             upd_we;
  logic [2:0]       rd_idx;
  logic [31:0]      rd_dat;
  logic             idle_hit;
  logic             write_hit;
  logic             unused_ok;

  assign unused_ok = &{1'b0, s_adr_i[1:0]};

  // A coincident invalidate must win over a hit in the same cycle.
  assign idle_hit  = valid_q && !invalidate && (tag_q == s_adr_i[sdram_depth-1:5]);
  assign write_hit = valid_q && (tag_q == adr_q[sdram_depth-1:5]);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    beat_d       = beat_q;
    adr_d        = adr_q;
    sdat_d       = sdat_q;
    inval_seen_d = inval_seen_q;
    dropped_d    = dropped_q;
    fill_we      = 1'b0;
    upd_we       = 1'b0;
    rd_idx       = adr_q[4:2];
    m_cyc_o      = 1'b0;
    m_stb_o      = 1'b0;
    m_we_o       = 1'b0;
    m_cti_o      = CTI_CLASSIC;
    m_sel_o      = 8'h00;
    m_adr_o      = 32'h0;
    m_dat_o      = 64'h0;

    unique case (state_q)
      ST_IDLE: begin
        rd_idx = s_adr_i[4:2];
        if (invalidate) valid_d = 1'b0;
        if (s_cyc_i && s_stb_i && !s_ack_o) begin
          adr_d = s_adr_i[31:2];
          if (s_we_i) begin
            state_d = ST_WRITE;
          end else if (idle_hit) begin
            sdat_d  = rd_dat;
            state_d = ST_ACK;
          end else begin
            beat_d       = 2'd0;
            valid_d      = 1'b0;
            inval_seen_d = 1'b0;
            dropped_d    = 1'b0;
            state_d      = ST_FILL;
          end
        end
      end

      // A burst cannot be aborted, so a vanished requester only suppresses the ack.
      ST_FILL: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_sel_o = 8'hFF;
        m_adr_o = {adr_q[31:5], beat_q, 3'b000};
        m_cti_o = (beat_q == 2'd3) ? CTI_END : CTI_INCR;
        if (invalidate) inval_seen_d = 1'b1;
        if (!s_cyc_i) dropped_d = 1'b1;
        if (m_ack_i) begin
          fill_we = 1'b1;
          beat_d  = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            tag_d   = adr_q[sdram_depth-1:5];
            valid_d = !(inval_seen_q || invalidate);
            if (adr_q[4:3] == 2'd3) begin
              sdat_d = adr_q[2] ? m_dat_i[31:0] : m_dat_i[63:32];
            end else begin
              sdat_d = rd_dat;
            end
            state_d = (dropped_q || !s_cyc_i) ? ST_IDLE : ST_ACK;
          end
        end
      end

      ST_WRITE: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_we_o  = 1'b1;
        m_adr_o = {adr_q[31:3], 3'b000};
        m_sel_o = adr_q[2] ? {4'b0000, s_sel_i} : {s_sel_i, 4'b0000};
        m_dat_o = {s_dat_i, s_dat_i};
        if (invalidate) valid_d = 1'b0;
        if (m_ack_i) begin
          upd_we  = write_hit;
          state_d = ST_ACK;
        end
      end

      ST_ACK: begin
        if (invalidate) valid_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      valid_q      <= 1'b0;
      tag_q        <= '0;
      beat_q       <= 2'd0;
      adr_q        <= '0;
      sdat_q       <= 32'h0;
      inval_seen_q <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      beat_q       <= beat_d;
      adr_q        <= adr_d;
      sdat_q       <= sdat_d;
      inval_seen_q <= inval_seen_d;
      dropped_q    <= dropped_d;
    end
  end

  assign s_ack_o = (state_q == ST_ACK);
  assign s_dat_o = sdat_q;

`ifdef HPDMC_WB32_NEXTADR_EN
  assign m_nextadr_valid_o = (state_q == ST_FILL);
  assign m_nextadr_o       = {adr_q[31:5], 5'b00000} + 32'(LINE_BYTES);
`else
  assign m_nextadr_valid_o = 1'b0;
  assign m_nextadr_o       = 32'h0;
`endif

  hpdmc_wb32_linebuf u_linebuf (
    .clk_i       (sys_clk),
    .fill_we_i   (fill_we),
    .fill_beat_i (beat_q),
    .fill_dat_i  (m_dat_i),
    .upd_we_i    (upd_we),
    .upd_idx_i   (adr_q[4:2]),
    .upd_sel_i   (s_sel_i),
    .upd_dat_i   (s_dat_i),
    .rd_idx_i    (rd_idx),
    .rd_dat_o    (rd_dat)
  );

endmodule

// File: tb/tb_hpdmc_wb32_bridge.sv
// Scoreboard bench for hpdmc_wb32_bridge: a memory responder on the 64-bit side,
// a reference cache/memory model, and a monitor that checks every slave ack.
module tb_hpdmc_wb32_bridge;

  logic        sys_clk, sys_rst;
  logic        invalidate, inv_drv, inv_resp;
  logic [31:0] s_adr_i, s_dat_i, s_dat_o;
  logic [3:0]  s_sel_i;
  logic        s_cyc_i, s_stb_i, s_we_i, s_ack_o;
  logic [31:0] m_adr_o;
  logic [2:0]  m_cti_o;
  logic [63:0] m_dat_o, m_dat_i;
  logic [7:0]  m_sel_o;
  logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i;
  logic        m_nextadr_valid_o;
  logic [31:0] m_nextadr_o;

  assign invalidate = inv_drv | inv_resp;

  hpdmc_wb32_bridge dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .invalidate(invalidate),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_sel_i(s_sel_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_ack_o(s_ack_o),
    .m_adr_o(m_adr_o), .m_cti_o(m_cti_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_sel_o(m_sel_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_ack_i(m_ack_i), .m_nextadr_valid_o(m_nextadr_valid_o), .m_nextadr_o(m_nextadr_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cycle = 0;
  always @(posedge sys_clk) cycle <= cycle + 1;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Both memories start from the same address hash so misses are predictable.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  logic [31:0] rmem   [logic [31:0]];
  logic [31:0] refmem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] wa = {a[31:2], 2'b00};
    return rmem.exists(wa) ? rmem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0] wa = {a[31:2], 2'b00};
    return refmem.exists(wa) ? refmem[wa] : init_word(wa);
  endfunction

  // Reference cache: one line copy, tag taken from address bits [25:5].
  bit          ref_valid = 0;
  logic [20:0] ref_tag   = '0;
  logic [31:0] ref_words [8];

  function automatic bit ref_hit(input logic [31:0] a);
    return ref_valid && (ref_tag == a[25:5]);
  endfunction

  task automatic ref_load(input logic [31:0] a, input bit inv);
    for (int w = 0; w < 8; w++) ref_words[w] = ref_rd({a[31:5], 3'(w), 2'b00});
    ref_tag   = a[25:5];
    ref_valid = !inv;
  endtask

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    bit          local_hit;
    int          burst_base;
    int          start_cycle;
  } sb_item_t;
  sb_item_t sb_q[$];

  logic [31:0] cur_adr, cur_dat;
  logic [3:0]  cur_sel;
  int          bursts = 0, rbeat = 0, inv_beat = -1, last_done = 0;
  bit          in_burst = 0, ack_random = 0;

  // Memory responder on the 64-bit port.
  initial begin
    m_ack_i  = 1'b0;
    m_dat_i  = 64'h0;
    inv_resp = 1'b0;
    forever begin
      @(negedge sys_clk);
      m_ack_i  = 1'b0;
      inv_resp = 1'b0;
      if (m_cyc_o && m_stb_o) begin
        if (!m_we_o && !in_burst) begin
          in_burst = 1;
          bursts++;
          rbeat = 0;
        end
        if (!ack_random || $urandom_range(1, 0) == 1) begin
          m_ack_i = 1'b1;
          if (m_we_o) begin
            check("wr_adr", 64'(m_adr_o), 64'({cur_adr[31:3], 3'b000}));
            check("wr_cti", 64'(m_cti_o), 64'(3'b000));
            check("wr_sel", 64'(m_sel_o), cur_adr[2] ? 64'({4'b0, cur_sel}) : 64'({cur_sel, 4'b0}));
            check("wr_dat", m_dat_o, {cur_dat, cur_dat});
            rmem[{m_adr_o[31:3], 3'b000}] = merge(mem_rd({m_adr_o[31:3], 3'b000}), m_dat_o[63:32], m_sel_o[7:4]);
            rmem[{m_adr_o[31:3], 3'b100}] = merge(mem_rd({m_adr_o[31:3], 3'b100}), m_dat_o[31:0], m_sel_o[3:0]);
            last_done = cycle;
          end else begin
            check("rd_adr", 64'(m_adr_o), 64'({cur_adr[31:5], 2'(rbeat), 3'b000}));
            check("rd_cti", 64'(m_cti_o), (rbeat == 3) ? 64'(3'b111) : 64'(3'b010));
            check("rd_sel", 64'(m_sel_o), 64'hFF);
`ifdef HPDMC_WB32_NEXTADR_EN
            check("nextadr_valid", 64'(m_nextadr_valid_o), 64'd1);
            check("nextadr", 64'(m_nextadr_o), 64'({cur_adr[31:5] + 27'd1, 5'b00000}));
`else
            check("nextadr_valid", 64'(m_nextadr_valid_o), 64'd0);
            check("nextadr", 64'(m_nextadr_o), 64'd0);
`endif
            m_dat_i  = {mem_rd({m_adr_o[31:3], 3'b000}), mem_rd({m_adr_o[31:3], 3'b100})};
            inv_resp = (rbeat == inv_beat);
            if (rbeat == 3) last_done = cycle;
            rbeat++;
          end
        end
      end else begin
        in_burst = 0;
      end
    end
  end

  // Monitor: every slave ack is matched against the oldest expected response.
  bit prev_ack = 0;
  initial begin
    sb_item_t it;
    forever begin
      @(negedge sys_clk);
      if (prev_ack) check("ack_pulse", 64'(s_ack_o), 64'd0);
      if (s_ack_o && !prev_ack) begin
        if (sb_q.size() == 0) begin
          check("spurious_ack", 64'(s_ack_o), 64'd0);
        end else begin
          it = sb_q.pop_front();
          if (it.is_read) check("read_data", 64'(s_dat_o), 64'(it.data));
          check("fill_bursts", 64'(bursts - it.burst_base),
                (it.is_read && !it.local_hit) ? 64'd1 : 64'd0);
          check("ack_latency", 64'(cycle),
                it.local_hit ? 64'(it.start_cycle + 1) : 64'(last_done + 1));
        end
      end
      prev_ack = s_ack_o;
    end
  end

  logic [31:0] last_dat;

  task automatic applyStimulus(input logic [31:0] a, input bit we, input logic [31:0] d,
                               input logic [3:0] sel);
    @(negedge sys_clk);
    cur_adr = a; cur_dat = d; cur_sel = sel;
    s_adr_i = a; s_dat_i = d; s_sel_i = sel; s_we_i = we;
    s_cyc_i = 1'b1; s_stb_i = 1'b1;
  endtask

  task automatic wait_ack();
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge sys_clk);
      if (s_ack_o) begin ok = 1; break; end
    end
    last_dat = s_dat_o;
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    if (!ok) check("ack_timeout", 64'(s_ack_o), 64'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input bit inv);
    sb_item_t it;
    bit hit = ref_hit(a);
    it.is_read   = 1;
    it.local_hit = hit;
    it.data      = hit ? ref_words[a[4:2]] : ref_rd(a);
    inv_beat     = inv ? 2 : -1;
    applyStimulus(a, 1'b0, 32'h0, 4'hF);
    it.burst_base  = bursts;
    it.start_cycle = cycle;
    sb_q.push_back(it);
    wait_ack();
    if (!hit) ref_load(a, inv);
    inv_beat = -1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
    sb_item_t it;
    applyStimulus(a, 1'b1, d, sel);
    it.is_read = 0; it.data = 32'h0; it.local_hit = 0;
    it.burst_base = bursts; it.start_cycle = cycle;
    sb_q.push_back(it);
    wait_ack();
    refmem[{a[31:2], 2'b00}] = merge(ref_rd(a), d, sel);
    if (ref_hit(a)) ref_words[a[4:2]] = merge(ref_words[a[4:2]], d, sel);
  endtask

  task automatic wait_beats(input int n);
    for (int k = 0; k < 200; k++) begin
      @(negedge sys_clk);
      if (in_burst && rbeat >= n) break;
    end
  endtask

  task automatic do_read_abort(input logic [31:0] a);
    applyStimulus(a, 1'b0, 32'h0, 4'hF);
    wait_beats(2);
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge sys_clk);
      if (!m_cyc_o) break;
    end
    check("abort_cyc_released", 64'(m_cyc_o), 64'd0);
    check("abort_all_beats", 64'(rbeat), 64'd4);
    ref_load(a, 1'b0);
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic do_read_reset(input logic [31:0] a);
    applyStimulus(a, 1'b0, 32'h0, 4'hF);
    wait_beats(2);
    sys_rst = 1'b1; s_cyc_i = 1'b0; s_stb_i = 1'b0;
    @(negedge sys_clk);
    check("rst_mid_cyc", 64'(m_cyc_o), 64'd0);
    check("rst_mid_stb", 64'(m_stb_o), 64'd0);
    check("rst_mid_ack", 64'(s_ack_o), 64'd0);
    check("rst_mid_nextadr_valid", 64'(m_nextadr_valid_o), 64'd0);
    sys_rst = 1'b0;
    ref_valid = 0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic pulse_inv();
    @(negedge sys_clk);
    inv_drv = 1'b1;
    @(negedge sys_clk);
    inv_drv = 1'b0;
    ref_valid = 0;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_s_ack"}, 64'(s_ack_o), 64'd0);
    check({tag, "_s_dat"}, 64'(s_dat_o), 64'd0);
    check({tag, "_m_cyc"}, 64'(m_cyc_o), 64'd0);
    check({tag, "_m_stb"}, 64'(m_stb_o), 64'd0);
    check({tag, "_m_we"}, 64'(m_we_o), 64'd0);
    check({tag, "_m_adr"}, 64'(m_adr_o), 64'd0);
    check({tag, "_m_sel"}, 64'(m_sel_o), 64'd0);
    check({tag, "_m_dat"}, m_dat_o, 64'd0);
    check({tag, "_nextadr_valid"}, 64'(m_nextadr_valid_o), 64'd0);
    check({tag, "_nextadr"}, 64'(m_nextadr_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] lines [5];

  initial begin
    logic [31:0] a;
    int r;
    lines[0] = 32'h0000_0000; lines[1] = 32'h0000_0020; lines[2] = 32'h0000_0100;
    lines[3] = 32'h0000_03E0; lines[4] = 32'h0000_7FE0;
    for (int k = 0; k < 4; k++) begin
      rmem[32'h100 + 32'(8*k)]   = 32'h1111_1111 * 32'(k + 1);
      rmem[32'h104 + 32'(8*k)]   = 32'h1111_1111 * 32'(k);
      refmem[32'h100 + 32'(8*k)] = 32'h1111_1111 * 32'(k + 1);
      refmem[32'h104 + 32'(8*k)] = 32'h1111_1111 * 32'(k);
    end

    sys_rst = 1'b1; inv_drv = 1'b0;
    s_adr_i = 32'h0; s_dat_i = 32'h0; s_sel_i = 4'h0;
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    repeat (3) @(negedge sys_clk);
    checkOutput("in_reset");
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checkOutput("after_reset");

    do_read(32'h0000_0108, 1'b0);
    check("tp_read_108", 64'(last_dat), 64'h2222_2222);
    do_read(32'h0000_011C, 1'b0);
    check("tp_hit_11c", 64'(last_dat), 64'h3333_3333);
    do_write(32'h0000_0104, 32'hDEAD_BEEF, 4'b0011);
    do_read(32'h0000_0104, 1'b0);
    check("tp_merged_104", 64'(last_dat), 64'h0000_BEEF);

    do_read(32'h0000_0200, 1'b1);
    do_read(32'h0000_0200, 1'b0);

    do_read_abort(32'h0000_0300);
    do_read(32'h0000_0304, 1'b0);

    do_read_reset(32'h0000_0400);
    do_read(32'h0000_0400, 1'b0);

`ifdef HPDMC_WB32_NEXTADR_EN
    do_read(32'hFFFF_FFE0, 1'b0);
`endif

    ack_random = 1;
    for (int n = 0; n < 80; n++) begin
      a = lines[$urandom_range(4, 0)] | {27'd0, 3'($urandom_range(7, 0)), 2'b00};
      r = $urandom_range(99, 0);
      if (r < 10) pulse_inv();
      else if (r < 40) do_write(a, $urandom, 4'($urandom_range(15, 1)));
      else do_read(a, 1'b0);
    end

    for (int k = 0; k < 50; k++) begin
      if (sb_q.size() == 0) break;
      @(negedge sys_clk);
    end
    repeat (3) @(negedge sys_clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hpdmc_wb32_bridge.md
Name: hpdmc_wb32_bridge

Overview:
- Upstream front-end of the memory controller: 32-bit classic WISHBONE slave for a CPU or DMA master.
- Drives the controller's 64-bit memory WISHBONE port.
- Reads: 4-beat incrementing bursts fill a one-line (32-byte) read buffer; subsequent hits are served locally.
- Writes: passed through as single 64-bit classic writes with byte lanes mapped; the address-prediction sideband is driven during fills.

Parameters:
- sdram_depth, 26, address bits [sdram_depth-1:5] form the line tag; higher bits ignored.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous active-high reset.
- invalidate  in  1  pulse; clears the line-buffer valid flag.
- s_adr_i  in  32  slave byte address; bit 2 selects the word within a 64-bit beat.
- s_dat_i  in  32  slave write data.
- s_dat_o  out  32  slave read data.
- s_sel_i  in  4  slave byte selects.
- s_cyc_i, s_stb_i, s_we_i  in  1  slave cycle, strobe, write.
- s_ack_o  out  1  slave ack, single-cycle pulse.
- m_adr_o  out  32  master byte address, 8-byte aligned.
- m_cti_o  out  3  cycle type.
- m_dat_o  out  64  master write data.
- m_dat_i  in  64  master read data.
- m_sel_o  out  8  master byte selects.
- m_cyc_o, m_stb_o, m_we_o  out  1  master cycle, strobe, write.
- m_ack_i  in  1  master ack.
- m_nextadr_valid_o  out  1  prediction valid.
- m_nextadr_o  out  32  predicted next read address.

Behaviour:
- Clocking: one clock, sys_clk; sys_rst synchronous, active-high.
- Reset values: all outputs 0; state IDLE; valid=0; tag=0; beat counter=0.
- Reset asserted mid-operation:
  - Takes effect at the next edge; m_cyc_o/m_stb_o fall and no s_ack_o is issued.
  - Valid is cleared and the partial line is discarded.
- Lane mapping (big-endian):
  - s_adr_i[2]=0 maps to m_dat[63:32] and m_sel[7:4].
  - s_adr_i[2]=1 maps to [31:0] and [3:0].
  - Unused lanes have sel=0; write data is replicated on both halves.
- Hit: valid && tag==s_adr_i[sdram_depth-1:5].
- States: IDLE, FILL, WRITE, ACK (encoded in the package).
- IDLE: request = s_cyc_i && s_stb_i && !s_ack_o.
  - Read hit -> ACK; s_dat_o loaded from the buffer.
  - Read miss -> FILL; beat=0, valid cleared.
  - Write -> WRITE.
- FILL:
  - m_cyc_o=m_stb_o=1, m_we_o=0, m_sel_o=8'hFF.
  - m_adr_o = {s_adr_i[31:5], beat, 3'b000}.
  - m_cti_o = 3'b010 for beats 0-2, 3'b111 for beat 3.
  - On each m_ack_i: store m_dat_i in slot beat; beat++.
  - On ack of beat 3: tag loaded; valid=1 unless invalidate seen during the fill; s_dat_o loaded from the requested word (bypassing storage for beat 3); -> ACK.
  - If s_cyc_i drops mid-fill, the burst completes (cannot abort), the buffer is still filled, and ACK is skipped (-> IDLE).
- WRITE:
  - m_cyc_o=m_stb_o=m_we_o=1, m_cti_o=3'b000, m_adr_o = {s_adr_i[31:3],3'b000}.
  - On m_ack_i: if hit, the buffer bytes selected by s_sel_i are updated (write-through) -> ACK.
- ACK: s_ack_o=1 for exactly one cycle -> IDLE. Master outputs drop on entry to ACK.
- Latency:
  - Read hit: s_ack_o one cycle after strobe sampled.
  - Miss: one cycle after the fourth m_ack_i.
  - Write: one cycle after m_ack_i.
- invalidate:
  - In IDLE/ACK/WRITE, clears valid at the next edge.
  - Simultaneous with a read request in IDLE: treated as a miss.
- m_nextadr: the base only drives it when the optional feature is enabled (see Optional Feature); otherwise both outputs are constant 0.

Optional Feature:
- Macro: HPDMC_WB32_NEXTADR_EN.
- Enabled: m_nextadr_valid_o=1 while in FILL; m_nextadr_o = {s_adr_i[31:5]+1, 5'b0}, i.e. next line, wrapping modulo 2^32.
- Disabled: m_nextadr_valid_o and m_nextadr_o are constant 0; no adder is synthesised.

Decomposition:
- Package hpdmc_pkg:
  - State encoding.
  - CTI constants: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111.
  - LINE_BEATS=4, LINE_BYTES=32.
- Sub-module hpdmc_wb32_linebuf: 4x64 storage, one full-beat write port (fill) and one byte-masked write port (write-through update), asynchronous word read by {beat, word-select}.

Test Plan:
- Read miss at 0x00000108 with m_ack_i on 4 consecutive cycles (data beats 0x1111..0_0000..0 through 0x4444..3_...):
  - m_adr_o = 0x100, 0x108, 0x110, 0x118; cti 010,010,010,111.
  - s_dat_o = upper word of beat 1; s_ack_o one cycle after the 4th ack.
- Following read of 0x0000011C: no master cycle; s_ack_o one cycle after strobe; s_dat_o = lower word of beat 3.
- Write 0xDEADBEEF, sel 4'b0011, to 0x00000104 (hit):
  - m_sel_o=8'h03; m_dat_o[31:0]=0xDEADBEEF.
  - A subsequent read of 0x104 returns the old upper two bytes with 0xBEEF in the lower half.
- invalidate pulsed during beat 2 of a fill to 0x200: fill completes and s_ack_o is returned; a re-read of 0x200 issues a new 4-beat burst.
- s_cyc_i dropped after beat 1 of a fill: all 4 beats still complete; no s_ack_o; a re-read of the same line hits.
- sys_rst asserted at beat 2: m_cyc_o=0 next cycle; no ack; valid=0; m_nextadr_valid_o=0.
- With HPDMC_WB32_NEXTADR_EN, fill at 0xFFFFFFE0: m_nextadr_o=0x00000000 (wrap).
